count_seq_monitor: RTL

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

---
 rtl/count_pkg.sv | 7 +
 rtl/sat_counter.sv | 17 +
 rtl/count_seq_monitor.sv | 72 +++++++
 3 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared state encoding and default parameters for count_seq_monitor.
package count_pkg;
  localparam int SYNC_LEN_DEF = 4;
  localparam int STAT_W_DEF = 8;
  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sync clear and async reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_d, count_q;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: tracks a mod-16 up-count stream, flags lock, loss of sequence and wraps.
module count_seq_monitor
  import count_pkg::*;
#(
  parameter int SYNC_LEN = SYNC_LEN_DEF,
  parameter int STAT_W   = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        count_in,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);
  localparam logic [3:0] SYNC_N = 4'(SYNC_LEN);
  logic [0:0] state_d, state_q;
  logic [3:0] match_cnt_d, match_cnt_q, prev_d, prev_q;
  logic       prev_valid_d, prev_valid_q, err_d, err_q, wrap_d, wrap_q;
  logic       match, mismatch;
  assign match    = prev_valid_q && count_in == prev_q + 4'd1;
  assign mismatch = prev_valid_q && !match;
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;
    prev_d       = clear ? 4'd0 : count_in;
    prev_valid_d = !clear;
    if (clear) begin
      state_d     = SEARCH;
      match_cnt_d = 4'd0;
    end else if (state_q == SEARCH) begin
      match_cnt_d = match ? match_cnt_q + 4'd1 : mismatch ? 4'd0 : match_cnt_q;
      if (match && match_cnt_q + 4'd1 == SYNC_N) begin
        state_d     = LOCKED;
        match_cnt_d = 4'd0;
      end
    end else begin
      err_d   = mismatch;
      wrap_d  = match && prev_q == 4'hf;
      state_d = mismatch ? SEARCH : LOCKED;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= SEARCH;
      match_cnt_q  <= 4'd0;
      prev_q       <= 4'd0;
      prev_valid_q <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
    end
  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk(clk), .rst(reset), .clr(clear), .inc(err_d), .count(err_count)
  );
  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk(clk), .rst(reset), .clr(clear), .inc(wrap_d), .count(wrap_count)
  );
  assign locked = state_q == LOCKED;
  assign err    = err_q;
  assign wrap   = wrap_q;
endmodule
